inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Instruction fetch stage directly upstream of the single-cycle-decode MIPS core (controller plus datapath).
- Generates sequential PCs and issues requests to instruction memory.
- Buffers returned words in a small in-order FIFO and presents instruction, PC, and pre-split opcode/func fields to the decode stage under a valid/ready handshake.
- Handles branch/jump redirects: flushes the queue and discards responses still in flight.

Parameters:
- DEPTH, 4: FIFO entries; also the cap on buffered plus outstanding fetches. Power of two, at least 2.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  32  byte address of the request; always word-aligned.
- imem_rsp_valid  input  1  response word valid. Responses are in order and arrive at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken; restart fetch.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and treated as 0.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode consumes the instruction this cycle.
- inst_data  output  32  instruction word.
- inst_pc  output  32  address of inst_data.
- opcode  output  6  inst_data[31:26].
- func  output  6  inst_data[5:0].

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC; FIFO empty with rd/wr pointers 0; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst_data/inst_pc/opcode/func=0.
  - Reset mid-operation abandons in-flight requests. Memory must also be reset, so no stale responses arrive.
- State: fetch_pc (32b), FIFO of DEPTH entries of {pc, word}, count (0..DEPTH), outstanding (0..DEPTH), drop_cnt (0..DEPTH).
- Issue:
  - imem_req_valid = (count + outstanding < DEPTH) && !redirect_valid.
  - imem_addr = fetch_pc.
  - On acceptance (valid && ready): fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt > 0: decrement drop_cnt and discard the word.
  - Otherwise push {pc, word}. The pc for each pushed entry is tracked by a separate rsp_pc register, incremented by 4 per kept response and loaded on redirect.
- Pop:
  - inst_valid = (count > 0) && !redirect_valid.
  - Head entry drives inst_data, inst_pc, opcode, func.
  - inst_valid && inst_ready advances rd pointer.
  - Push and pop in the same cycle leave count unchanged.
- Latency: a response is visible on inst_* the cycle after imem_rsp_valid.
- Redirect (highest priority):
  - fetch_pc and rsp_pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO cleared (count=0, pointers 0).
  - drop_cnt <= outstanding - imem_rsp_valid. Any response in the redirect cycle is discarded.
  - No request is issued and no pop occurs in that cycle.
  - Back-to-back redirects: each one recomputes drop_cnt from current outstanding; drop_cnt never underflows.
- Full: with count + outstanding == DEPTH, requests stall. No overflow is possible by construction.
- Empty: inst_valid=0; outputs hold the last head value (don't-care).
- Illegal input: imem_rsp_valid with outstanding==0 is illegal. The bench asserts on it; RTL ignores it.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- When defined: if count==0, drop_cnt==0, no redirect, and imem_rsp_valid, then inst_valid=1 in the same cycle, with inst_* driven combinationally from imem_rsp_data/rsp_pc.
  - If inst_ready is also 1, the word is consumed and not written into the FIFO.
  - Otherwise it is pushed as normal.
- When undefined: no combinational path from imem_rsp_* to inst_*; minimum latency 1 cycle.

Test Plan:
- Reset then stream, imem_req_ready=1, 1-cycle response, inst_ready=1 → inst_pc sequence 0x0,0x4,0x8,...; first inst_valid 2 cycles after reset release (1 with IFQ_BYPASS_EN).
- Backpressure: inst_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; release → 4 instructions in order, no loss or duplication.
- Redirect with 2 outstanding: redirect_pc=0x100 → next 2 responses dropped, next inst_pc=0x100 with the word fetched from 0x100.
- Redirect coinciding with a response and a pop → response discarded, inst_valid=0 that cycle, queue empty next cycle, fetch resumes at redirect_pc.
- Async reset asserted mid-stream between clock edges → outputs zero immediately; after release, fetch restarts at RESET_PC.
- PC wrap: redirect_pc=0xFFFF_FFFC → following request address 0x0000_0000; redirect_pc=0x103 → fetch at 0x100.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and decode.
// master: the fetch queue; slave: the memory/decode environment.
interface inst_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic [5:0]  func;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, opcode, func,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, opcode, func,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: sequential PC generation, in-order response FIFO,
// redirect flush with in-flight response dropping.
// Optional macro IFQ_BYPASS_EN: combinational response-to-decode bypass when
// the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic          w_redir;
  logic [31:0]   w_redir_pc;
  logic [1:0]    w_unused_pc_lsb;
  logic [SW-1:0] w_occupancy;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_rsp;
  logic          w_keep;
  logic          w_head_valid;
  logic [31:0]   w_head_data;
  logic [31:0]   w_head_pc;
  logic          w_inst_valid;
  logic [31:0]   w_inst_data;
  logic [31:0]   w_inst_pc;
  logic          w_push;
  logic          w_pop;

  assign w_redir         = bus.redirect_valid;
  assign w_redir_pc      = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = bus.redirect_pc[1:0];

  // Buffered plus outstanding fetches never exceed DEPTH, so the FIFO cannot overflow.
  assign w_occupancy  = SW'(r_count) + SW'(r_outstanding);
  assign w_req_valid  = !rst && !w_redir && (w_occupancy < DEPTH_S);
  assign w_accept     = w_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is ignored.
  assign w_rsp        = bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_keep       = w_rsp && (r_drop_cnt == '0) && !w_redir;
  assign w_head_valid = (r_count != '0);
  assign w_head_data  = r_mem_data[r_rd_ptr];
  assign w_head_pc    = r_mem_pc[r_rd_ptr];

`ifdef IFQ_BYPASS_EN
  // Bypass only when the queue is empty, so ordering is preserved; a bypassed
  // word that decode takes is never written into the FIFO.
  logic w_bypass;
  assign w_bypass     = w_keep && !w_head_valid;
  assign w_inst_valid = (w_head_valid || w_bypass) && !w_redir;
  assign w_inst_data  = w_bypass ? bus.imem_rsp_data : w_head_data;
  assign w_inst_pc    = w_bypass ? r_rsp_pc : w_head_pc;
  assign w_pop        = w_head_valid && !w_redir && bus.inst_ready;
  assign w_push       = w_keep && !(w_bypass && bus.inst_ready);
`else
  assign w_inst_valid = w_head_valid && !w_redir;
  assign w_inst_data  = w_head_data;
  assign w_inst_pc    = w_head_pc;
  assign w_pop        = w_inst_valid && bus.inst_ready;
  assign w_push       = w_keep;
`endif

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_fetch_pc;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst_data      = w_inst_data;
  assign bus.inst_pc        = w_inst_pc;
  assign bus.opcode         = w_inst_data[31:26];
  assign bus.func           = w_inst_data[5:0];

  // Fetch/response PCs, FIFO pointers and occupancy counters; redirect wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (w_redir) begin
      r_fetch_pc    <= w_redir_pc;
      r_rsp_pc      <= w_redir_pc;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      // Every fetch still in flight after this cycle belongs to the old path.
      r_outstanding <= r_outstanding - CW'(w_rsp);
      r_drop_cnt    <= r_outstanding - CW'(w_rsp);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
      if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      if (w_keep) r_rsp_pc <= r_rsp_pc + 32'd4;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.imem_rsp_data;
      r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: memory model with in-order
// responses, decode sink, and a stream-level reference of expected PCs/words.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  inst_fetch_queue_if ifc ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus knobs (percent probabilities)
  int p_ready, p_inst, p_rsp, p_redir;
  bit force_redir;
  logic [31:0] force_pc;

  // memory in-flight requests; stale = fetched on a path abandoned by redirect
  logic [31:0] fl_addr[$];
  bit          fl_stale[$];

  // reference: words buffered for decode, next fetch address, next decode PC
  int          m_count;
  logic [31:0] exp_fetch, exp_pop;
  int          npops;

  // observations of the last step
  bit          o_req_valid, o_inst_valid, o_acc, o_pop;
  logic [31:0] o_addr, o_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive at negedge, check outputs against the reference, update at posedge.
  task automatic step();
    bit redir, rsp, exp_rv, exp_iv, byp, kept, acc, pop;
    logic [31:0] rpc, w;
    @(negedge clk);
    ifc.imem_req_ready = ($urandom_range(0, 99) < p_ready);
    ifc.inst_ready     = ($urandom_range(0, 99) < p_inst);
    redir = force_redir || ($urandom_range(0, 99) < p_redir);
    rpc   = force_redir ? force_pc : ($urandom & 32'h0000_3FFF);
    rsp   = (fl_addr.size() != 0) && ($urandom_range(0, 99) < p_rsp);
    ifc.redirect_valid = redir;
    ifc.redirect_pc    = rpc;
    ifc.imem_rsp_valid = rsp;
    ifc.imem_rsp_data  = $urandom;
    if (rsp && !fl_stale[0]) ifc.imem_rsp_data = mem_word(fl_addr[0]);
    assert (!(rsp && fl_addr.size() == 0));
    #1;
    exp_rv = ((m_count + fl_addr.size()) < DEPTH) && !redir;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = rsp && !redir && (m_count == 0) && !fl_stale[0];
`endif
    exp_iv = ((m_count > 0) || byp) && !redir;
    n_cmp++;
    if (ifc.imem_req_valid !== exp_rv) begin
      n_bad++;
      $display("FAIL req_valid: got %b want %b at %0t", ifc.imem_req_valid, exp_rv, $time);
    end
    if (exp_rv) begin
      n_cmp++;
      if (ifc.imem_addr !== exp_fetch) begin
        n_bad++;
        $display("FAIL imem_addr: got %h want %h", ifc.imem_addr, exp_fetch);
      end
    end
    n_cmp++;
    if (ifc.inst_valid !== exp_iv) begin
      n_bad++;
      $display("FAIL inst_valid: got %b want %b at %0t", ifc.inst_valid, exp_iv, $time);
    end
    if (exp_iv) begin
      w = mem_word(exp_pop);
      n_cmp++;
      if ({ifc.inst_pc, ifc.inst_data, ifc.opcode, ifc.func} !== {exp_pop, w, w[31:26], w[5:0]}) begin
        n_bad++;
        $display("FAIL inst_out: got pc=%h data=%h op=%h fn=%h want pc=%h data=%h op=%h fn=%h",
                 ifc.inst_pc, ifc.inst_data, ifc.opcode, ifc.func, exp_pop, w, w[31:26], w[5:0]);
      end
    end
    acc = ifc.imem_req_valid && ifc.imem_req_ready;
    pop = ifc.inst_valid && ifc.inst_ready;
    o_req_valid  = ifc.imem_req_valid;
    o_inst_valid = ifc.inst_valid;
    o_addr       = ifc.imem_addr;
    o_pc         = ifc.inst_pc;
    o_acc        = acc;
    o_pop        = pop;
    @(posedge clk);
    kept = 1'b0;
    if (rsp) begin
      kept = !fl_stale[0] && !redir;
      void'(fl_addr.pop_front());
      void'(fl_stale.pop_front());
    end
    if (redir) begin
      foreach (fl_stale[i]) fl_stale[i] = 1'b1;
      m_count   = 0;
      exp_fetch = {rpc[31:2], 2'b00};
      exp_pop   = {rpc[31:2], 2'b00};
    end else begin
      m_count = m_count + int'(kept) - int'(pop);
      if (pop) begin
        exp_pop = exp_pop + 32'd4;
        npops++;
      end
      if (acc) begin
        fl_addr.push_back(exp_fetch);
        fl_stale.push_back(1'b0);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
  endtask

  task automatic set_knobs(input int r, input int i, input int s, input int d);
    p_ready = r; p_inst = i; p_rsp = s; p_redir = d;
  endtask

  // Assert reset between clock edges; memory model is reset with it.
  task automatic reset_assert();
    @(negedge clk);
    #2;
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.inst_ready     = 1'b0;
    rst = 1'b1;
    fl_addr.delete();
    fl_stale.delete();
    m_count   = 0;
    exp_fetch = RESET_PC;
    exp_pop   = RESET_PC;
  endtask

  task automatic reset_release();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_acc(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      ok = o_acc;
    end
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      step();
      ok = o_pop;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reset_assert();
    #1;
    n_cmp++; if (ifc.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", ifc.imem_req_valid); end
    n_cmp++; if (ifc.inst_valid !== 1'b0)     begin n_bad++; $display("FAIL rst_inst_valid: got %b want 0", ifc.inst_valid); end
    n_cmp++; if (ifc.inst_data !== 32'h0)     begin n_bad++; $display("FAIL rst_inst_data: got %h want 0", ifc.inst_data); end
    n_cmp++; if (ifc.inst_pc !== 32'h0)       begin n_bad++; $display("FAIL rst_inst_pc: got %h want 0", ifc.inst_pc); end
    n_cmp++; if ({ifc.opcode, ifc.func} !== 12'h0) begin n_bad++; $display("FAIL rst_fields: got %h want 0", {ifc.opcode, ifc.func}); end
    reset_release();
  endtask

  task automatic test_stream();
    int first, p0;
    int want_first, want_pops;
    set_knobs(100, 100, 100, 0);
    first = -1;
    p0 = npops;
`ifdef IFQ_BYPASS_EN
    want_first = 1; want_pops = 19;
`else
    want_first = 2; want_pops = 18;
`endif
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0) begin
        n_cmp++;
        if (!(o_req_valid && o_addr === RESET_PC)) begin
          n_bad++; $display("FAIL first_req: got v=%b addr=%h want v=1 addr=%h", o_req_valid, o_addr, RESET_PC);
        end
      end
      if (o_inst_valid && first < 0) first = k;
    end
    n_cmp++; if (first != want_first) begin n_bad++; $display("FAIL first_valid_cycle: got %0d want %0d", first, want_first); end
    n_cmp++; if (npops - p0 != want_pops) begin n_bad++; $display("FAIL stream_pops: got %0d want %0d", npops - p0, want_pops); end
  endtask

  task automatic test_backpressure();
    int nacc, p0;
    reset_assert();
    reset_release();
    set_knobs(100, 0, 100, 0);
    nacc = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      nacc += int'(o_acc);
    end
    n_cmp++; if (nacc != DEPTH) begin n_bad++; $display("FAIL bp_requests: got %0d want %0d", nacc, DEPTH); end
    n_cmp++; if (o_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got %b want 0", o_req_valid); end
    set_knobs(100, 100, 100, 0);
    p0 = npops;
    for (int k = 0; k < 6; k++) step();
    n_cmp++; if (npops - p0 < DEPTH) begin n_bad++; $display("FAIL bp_drain: got %0d want >=%0d", npops - p0, DEPTH); end
  endtask

  task automatic test_redirect();
    bit ok;
    reset_assert();
    reset_release();
    set_knobs(100, 100, 0, 0);
    step();
    step();
    n_cmp++; if (fl_addr.size() != 2) begin n_bad++; $display("FAIL redir_setup: got %0d outstanding want 2", fl_addr.size()); end
    force_redir = 1'b1; force_pc = 32'h0000_0100;
    step();
    force_redir = 1'b0;
    set_knobs(100, 100, 100, 0);
    wait_pop(ok);
    n_cmp++; if (!ok || o_pc !== 32'h100) begin n_bad++; $display("FAIL redir_first_pc: got ok=%b pc=%h want pc=00000100", ok, o_pc); end
  endtask

  task automatic test_redirect_collide();
    bit ok;
    reset_assert();
    reset_release();
    set_knobs(100, 100, 100, 0);
    for (int k = 0; k < 4; k++) step();
    force_redir = 1'b1; force_pc = 32'h0000_0200;
    step();
    force_redir = 1'b0;
    n_cmp++; if (o_inst_valid !== 1'b0) begin n_bad++; $display("FAIL collide_valid: got %b want 0", o_inst_valid); end
    step();
    n_cmp++; if (o_inst_valid !== 1'b0) begin n_bad++; $display("FAIL collide_empty: got %b want 0", o_inst_valid); end
    n_cmp++; if (!(o_acc && o_addr === 32'h200)) begin n_bad++; $display("FAIL collide_resume: got acc=%b addr=%h want acc=1 addr=00000200", o_acc, o_addr); end
  endtask

  task automatic test_wrap();
    bit ok;
    set_knobs(100, 100, 100, 0);
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    step();
    force_redir = 1'b0;
    wait_acc(ok);
    n_cmp++; if (!ok || o_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_a: got ok=%b addr=%h want fffffffc", ok, o_addr); end
    wait_acc(ok);
    n_cmp++; if (!ok || o_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_b: got ok=%b addr=%h want 00000000", ok, o_addr); end
    force_redir = 1'b1; force_pc = 32'h0000_0103;
    step();
    force_redir = 1'b0;
    wait_acc(ok);
    n_cmp++; if (!ok || o_addr !== 32'h100) begin n_bad++; $display("FAIL align: got ok=%b addr=%h want 00000100", ok, o_addr); end
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_async_reset();
    bit ok;
    set_knobs(80, 70, 60, 0);
    for (int k = 0; k < 30; k++) step();
    reset_assert();
    #1;
    n_cmp++; if (ifc.imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL arst_req_valid: got %b want 0", ifc.imem_req_valid); end
    n_cmp++; if (ifc.inst_valid !== 1'b0)     begin n_bad++; $display("FAIL arst_inst_valid: got %b want 0", ifc.inst_valid); end
    n_cmp++; if ({ifc.inst_data, ifc.inst_pc} !== 64'h0) begin n_bad++; $display("FAIL arst_outputs: got data=%h pc=%h want 0", ifc.inst_data, ifc.inst_pc); end
    reset_release();
    set_knobs(100, 100, 100, 0);
    wait_acc(ok);
    n_cmp++; if (!ok || o_addr !== RESET_PC) begin n_bad++; $display("FAIL arst_restart: got ok=%b addr=%h want %h", ok, o_addr, RESET_PC); end
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_random();
    int p0;
    p0 = npops;
    for (int blk = 0; blk < 6; blk++) begin
      set_knobs($urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 6));
      for (int k = 0; k < 500; k++) step();
    end
    n_cmp++; if (npops - p0 < 200) begin n_bad++; $display("FAIL random_progress: got %0d pops want >=200", npops - p0); end
  endtask

  initial begin
    force_redir = 1'b0;
    force_pc    = '0;
    npops       = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
